// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam int unsigned INSTR_STEP = 4;

    localparam int unsigned ENTRY_XLEN = 32;
    localparam int unsigned ENTRY_ILEN = 32;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] pc;
        logic [ENTRY_ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; a pop frees space for a push in the same cycle.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_q];

    // Flush wins over a same-cycle push: that data belongs to the abandoned path.
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, next-PC select, pipelined imem reads and a decode-side queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       ILEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int unsigned       FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            redirect_valid,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] alu_result,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

    logic [XLEN-1:0]      pc_q, pc_d, pc_seq, tag_pc;
    logic [CW-1:0]        q_count, outstanding, drop_q, drop_d;
    logic [CW:0]          in_use;
    logic                 q_full, q_empty, tag_full, tag_empty;
    logic                 req_fire, resp_drop, resp_keep, if_pop;
    logic [XLEN+ILEN-1:0] q_out;

    assign pc_seq = pc_q + XLEN'(INSTR_STEP);
    assign in_use = {1'b0, q_count} + {1'b0, outstanding};

    // Queue entries plus reads in flight never exceed the queue size, so responses always fit.
    assign imem_req_valid = !reset && pc_write && !redirect_valid
                            && (in_use < (CW + 1)'(FQ_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (drop_q != '0);
    assign resp_keep = imem_resp_valid && (drop_q == '0);

    assign if_valid           = !q_empty;
    assign if_pop             = if_valid && if_ready;
    assign {if_pc, if_instr}  = q_out;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            case (pc_src)
                PCSRC_BRANCH: pc_d = branch_target;
                PCSRC_JALR:   pc_d = {alu_result[XLEN-1:1], 1'b0};
                default:      pc_d = pc_seq;
            endcase
            // Every read still in flight after this cycle's response is on the old path.
            drop_d = outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire)  pc_d   = pc_seq;
            if (resp_drop) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // Tag FIFO occupancy is the count of outstanding reads.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (imem_resp_valid),
        .flush     (1'b0),
        .pop_data  (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outstanding)
    );

    fetch_queue #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (FQ_DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_keep),
        .push_data ({tag_pc, imem_resp_data}),
        .pop       (if_pop),
        .flush     (redirect_valid),
        .pop_data  (q_out),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (q_count <= CW'(FQ_DEPTH));
            assert (in_use <= (CW + 1)'(FQ_DEPTH));
            assert (drop_q <= outstanding);
            assert (!(req_fire && tag_full));
            assert (!(imem_resp_valid && tag_empty));
            assert (!(resp_keep && q_full));
        end
    end

endmodule
